// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding an 8N1 UART transmitter (8E1 when UART_TX_PARITY_EN is defined).
// Latency: a byte pushed into an empty, idle block makes txd fall on the 2nd rising edge after acceptance.
// Backpressure: tx_ready = FIFO not full; a byte offered while full is dropped and sets the sticky ovf flag.
//
// Ports:
//   clk        - system clock, all logic on its rising edge
//   n_rst      - synchronous active-low reset
//   tx_data    - byte to transmit, qualified by uout_valid
//   uout_valid - one-clock strobe per byte
//   tx_ready   - FIFO not full
//   txd        - registered serial line, idles high
//   tx_busy    - a frame is in progress or bytes are still buffered
//   ovf        - sticky: a byte was dropped on a full FIFO
//
// Macro UART_TX_PARITY_EN adds an even-parity bit between the data bits and the stop bit.
module uart_tx_fifo #(
    parameter int BAUD_DIV   = 434,
    parameter int FIFO_DEPTH = 8
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic [7:0] tx_data,
    input  logic       uout_valid,
    output logic       tx_ready,
    output logic       txd,
    output logic       tx_busy,
    output logic       ovf
);

    localparam int               AW        = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [15:0]      BAUD_LAST = 16'(BAUD_DIV - 1);
    localparam logic [AW:0]      FULL_CNT  = (AW + 1)'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        PAR   = 3'd3,
        STOP  = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd4
    } state_t;
`endif

    state_t          state_q, state_d;
    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [AW:0]     count_q;
    logic [15:0]     baud_q, baud_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            txd_q, txd_d;
    logic            ovf_q;
    logic            full, push, pop, baud_end, fifo_nempty;
    logic [7:0]      head;
`ifdef UART_TX_PARITY_EN
    logic            par_q, par_d;
`endif

    assign full        = (count_q == FULL_CNT);
    assign fifo_nempty = (count_q != '0);
    // Full is taken from the registered count, so a pop on the same edge never frees room for a push.
    assign push        = uout_valid && !full;
    assign head        = mem_q[rd_ptr_q];
    assign baud_end    = (baud_q == BAUD_LAST);

    assign tx_ready = !full;
    assign tx_busy  = (state_q != IDLE) || fifo_nempty;
    assign txd      = txd_q;
    assign ovf      = ovf_q;

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q + 16'd1;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        txd_d   = 1'b1;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        unique case (state_q)
            IDLE: begin
                baud_d = '0;
                if (fifo_nempty) begin
                    pop     = 1'b1;
                    shift_d = head;
`ifdef UART_TX_PARITY_EN
                    par_d   = ^head;
`endif
                    state_d = START;
                end
            end
            START: begin
                txd_d = 1'b0;
                if (baud_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                txd_d = shift_q[0];
                if (baud_end) begin
                    baud_d  = '0;
                    shift_d = {1'b1, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PAR;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PAR: begin
                txd_d = par_q;
                if (baud_end) begin
                    baud_d  = '0;
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                txd_d = 1'b1;
                if (baud_end) begin
                    baud_d = '0;
                    // Chain straight into the next start bit so queued frames leave no idle gap.
                    if (fifo_nempty) begin
                        pop     = 1'b1;
                        shift_d = head;
`ifdef UART_TX_PARITY_EN
                        par_d   = ^head;
`endif
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                baud_d  = '0;
                state_d = IDLE;
            end
        endcase
    end

    // Buffer storage needs no reset: the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= tx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q  <= IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= 8'hFF;
            txd_q    <= 1'b1;
            ovf_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
`ifdef UART_TX_PARITY_EN
            par_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            // txd follows the state held during the previous clock, hence the extra edge of latency.
            txd_q   <= txd_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
            if (uout_valid && full) begin
                ovf_q <= 1'b1;
            end
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + (AW + 1)'(1);
                2'b01:   count_q <= count_q - (AW + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed and randomized stimulus for uart_tx_fifo with BAUD_DIV=4, FIFO_DEPTH=8.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench); the reference model decides which offered bytes are accepted.
module tb_uart_tx_fifo;

    localparam int BD    = 4;
    localparam int DEPTH = 8;
`ifdef UART_TX_PARITY_EN
    localparam int NB    = 11;
`else
    localparam int NB    = 10;
`endif
    localparam int FLEN  = BD * NB;

    logic       clk;
    logic       n_rst;
    logic [7:0] tx_data;
    logic       uout_valid;
    logic       tx_ready;
    logic       txd;
    logic       tx_busy;
    logic       ovf;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference model: a queue of buffered bytes, the byte on the line and the clocks left in its frame.
    logic [7:0] mq[$];
    logic [7:0] m_cur;
    int         m_flen;
    logic       m_txd;
    logic       m_ovf;

    uart_tx_fifo #(.BAUD_DIV(BD), .FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .tx_data    (tx_data),
        .uout_valid (uout_valid),
        .tx_ready   (tx_ready),
        .txd        (txd),
        .tx_busy    (tx_busy),
        .ovf        (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic frame_bit(input logic [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx-1];
`ifdef UART_TX_PARITY_EN
        if (idx == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    // One clock: drive inputs, advance the model over the edge, then compare all outputs.
    task automatic step(input logic v, input logic [7:0] d, input logic r);
        logic nt;
        logic acc;
        uout_valid = v;
        tx_data    = d;
        n_rst      = r;
        @(posedge clk);
        cyc++;
        if (!r) begin
            mq.delete();
            m_flen = 0;
            m_ovf  = 1'b0;
            m_txd  = 1'b1;
        end else begin
            nt = 1'b1;
            if (m_flen > 0) nt = frame_bit(m_cur, (FLEN - m_flen) / BD);
            acc = v && (mq.size() < DEPTH);
            if (m_flen <= 1 && mq.size() > 0) begin
                m_cur  = mq.pop_front();
                m_flen = FLEN;
            end else if (m_flen > 0) begin
                m_flen--;
            end
            if (acc) mq.push_back(d);
            else if (v) m_ovf = 1'b1;
            m_txd = nt;
        end
        #1;
        chk("txd",      16'(txd),      16'(m_txd));
        chk("tx_ready", 16'(tx_ready), 16'(mq.size() < DEPTH));
        chk("tx_busy",  16'(tx_busy),  16'((m_flen > 0) || (mq.size() > 0)));
        chk("ovf",      16'(ovf),      16'(m_ovf));
    endtask

    // Single byte from idle: exact waveform, first-fall latency and busy release time.
    task automatic directed_frame(input logic [7:0] b);
        logic [10:0] fb;
        int          first_low;
`ifdef UART_TX_PARITY_EN
        fb = {1'b1, ^b, b, 1'b0};
`else
        fb = {2'b11, b, 1'b0};
`endif
        first_low = -1;
        step(1'b1, b, 1'b1);
        for (int k = 1; k <= FLEN + 4; k++) begin
            step(1'b0, 8'h00, 1'b1);
            if (txd == 1'b0 && first_low < 0) first_low = k;
            if (k >= 2 && k <= FLEN + 1) chk("wave", 16'(txd), 16'(fb[(k-2)/BD]));
            else                         chk("wave_idle", 16'(txd), 16'd1);
            if (k == FLEN)     chk("busy_end", 16'(tx_busy), 16'd1);
            if (k == FLEN + 1) chk("busy_off", 16'(tx_busy), 16'd0);
        end
        chk("latency", 16'(first_low), 16'd2);
    endtask

    initial begin
        logic [7:0] msg [4];
        int         n;
        int         lows;

        n_rst      = 1'b0;
        uout_valid = 1'b0;
        tx_data    = 8'h00;
        m_cur      = 8'hFF;
        m_flen     = 0;
        m_txd      = 1'b1;
        m_ovf      = 1'b0;

        // Reset state.
        step(1'b0, 8'h00, 1'b0);
        step(1'b1, 8'hA5, 1'b0);
        chk("rst_txd",   16'(txd),      16'd1);
        chk("rst_ready", 16'(tx_ready), 16'd1);
        chk("rst_busy",  16'(tx_busy),  16'd0);
        chk("rst_ovf",   16'(ovf),      16'd0);
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1);

        // Single frames.
`ifdef UART_TX_PARITY_EN
        directed_frame(8'h2B);
        chk("par_2B", 16'(^8'h2B), 16'(frame_bit(8'h2B, 9)));
        directed_frame(8'h2A);
`else
        directed_frame(8'h31);
        directed_frame(8'h2A);
`endif

        // Four bytes back to back: contiguous frames, busy drops exactly after four frame times.
        msg[0] = 8'h49; msg[1] = 8'h3D; msg[2] = 8'h33; msg[3] = 8'h44;
        for (int i = 0; i < 4; i++) step(1'b1, msg[i], 1'b1);
        n = 3;
        while (tx_busy && n < 1000) begin
            step(1'b0, 8'h00, 1'b1);
            n++;
        end
        chk("burst_len", 16'(n), 16'(1 + 4 * FLEN));

        // Ten bytes back to back: one goes on the line, eight buffered, tenth dropped.
        for (int i = 0; i < 10; i++) step(1'b1, 8'(8'h60 + i), 1'b1);
        chk("full_ready", 16'(tx_ready), 16'd0);
        chk("full_ovf",   16'(ovf),      16'd1);
        n = 0;
        while (tx_busy && n < 2000) begin
            step(1'b0, 8'h00, 1'b1);
            n++;
        end
        chk("drain_done", 16'(tx_busy), 16'd0);
        chk("ovf_held",   16'(ovf),     16'd1);

        // Reset during data bit 3 aborts the frame.
        step(1'b1, 8'h5A, 1'b1);
        for (int k = 1; k <= 17; k++) step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0);
        chk("abort_txd",   16'(txd),      16'd1);
        chk("abort_busy",  16'(tx_busy),  16'd0);
        chk("abort_ready", 16'(tx_ready), 16'd1);
        chk("abort_ovf",   16'(ovf),      16'd0);
        lows = 0;
        for (int k = 0; k < 60; k++) begin
            step(1'b0, 8'h00, 1'b1);
            if (txd == 1'b0) lows++;
        end
        chk("abort_quiet", 16'(lows), 16'd0);

        // Random traffic: sparse then dense offers, occasional reset.
        for (int i = 0; i < 3000; i++) begin
            logic v;
            logic r;
            v = (i < 1500) ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 2) == 0);
            r = ($urandom_range(0, 699) != 0);
            step(v, 8'($urandom), r);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
